// File: rtl/video_timing_pkg.sv
// Shared raster timing types and decode helpers for the video output stage.
package video_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    function automatic int unsigned total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    // Keeps counters at least one bit wide for degenerate one-entry totals.
    function automatic int unsigned cnt_width(int unsigned tot);
        return (tot > 1) ? $clog2(tot) : 1;
    endfunction

    function automatic logic in_region(int unsigned c, int unsigned lo, int unsigned len);
        return (c >= lo) && (c < lo + len);
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with active, sync and start-of-frame decode.
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter timing_t H = '{active: 1920, fp: 88, sync: 44, bp: 148},
    parameter timing_t V = '{active: 1080, fp: 4, sync: 5, bp: 36}
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic en_i,
    output logic active_o,
    output logic hs_o,
    output logic vs_o,
    output logic sof_o
);

    localparam int unsigned HTotal = total(H);
    localparam int unsigned VTotal = total(V);
    localparam int unsigned HW = cnt_width(HTotal);
    localparam int unsigned VW = cnt_width(VTotal);

    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else if (en_i) begin
            if (h_q == HW'(HTotal - 1)) begin
                h_q <= '0;
                if (v_q == VW'(VTotal - 1)) begin
                    v_q <= '0;
                end else begin
                    v_q <= v_q + 1'b1;
                end
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    // VS is decoded on v alone, so it toggles only when h wraps to 0.
    assign active_o = in_region(32'(h_q), 0, H.active) && in_region(32'(v_q), 0, V.active);
    assign hs_o     = in_region(32'(h_q), H.active + H.fp, H.sync);
    assign vs_o     = in_region(32'(v_q), V.active + V.fp, V.sync);
    assign sof_o    = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/video_out_timing.sv
// Final video stage: raster timing generation, FIFO pop and underflow fill/reporting.
module video_out_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned WIDTH    = 24,
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_FP     = 88,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_BP     = 148,
    parameter int unsigned V_ACTIVE = 1080,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 36,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter logic [WIDTH-1:0] FILL = '0
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             en_i,
    input  logic             in_val_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_rdy_o,
    output logic             vid_de_o,
    output logic             vid_hs_o,
    output logic             vid_vs_o,
    output logic [WIDTH-1:0] vid_data_o,
    output logic             sof_o,
    output logic             underflow_o,
    output logic [15:0]      underflow_cnt_o
);

    localparam timing_t HT = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t VT = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

    state_t state_q;
    logic   active, hs, vs, sof;

    video_timing_counter #(
        .H (HT),
        .V (VT)
    ) u_counter (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .en_i     ((state_q == StRun) && en_i),
        .active_o (active),
        .hs_o     (hs),
        .vs_o     (vs),
        .sof_o    (sof)
    );

    // Reset blocks the pop in its own cycle so no FIFO word is lost.
    assign in_rdy_o = (state_q == StRun) && en_i && active && !srst_i;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q         <= StIdle;
            vid_de_o        <= 1'b0;
            vid_hs_o        <= ~HS_POL;
            vid_vs_o        <= ~VS_POL;
            vid_data_o      <= '0;
            sof_o           <= 1'b0;
            underflow_o     <= 1'b0;
            underflow_cnt_o <= '0;
        end else if (en_i) begin
            unique case (state_q)
                StIdle: begin
                    if (in_val_i) state_q <= StRun;
                end
                StRun: begin
                    vid_de_o <= active;
                    vid_hs_o <= hs ? HS_POL : ~HS_POL;
                    vid_vs_o <= vs ? VS_POL : ~VS_POL;
                    sof_o    <= sof;
                    if (!active) begin
                        vid_data_o <= '0;
                    end else if (in_val_i) begin
                        vid_data_o <= in_data_i;
                    end else begin
                        // Keep the raster running; substitute fill and record the miss.
                        vid_data_o  <= FILL;
                        underflow_o <= 1'b1;
                        if (underflow_cnt_o != 16'hFFFF) begin
                            underflow_cnt_o <= underflow_cnt_o + 16'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_video_out_timing.sv
// Randomised/directed bench for video_out_timing against a position-based raster model.
module tb_video_out_timing;

    localparam int HT = 8;
    localparam int VT = 6;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        srst, en, in_val;
    logic [7:0]  in_data;
    logic        in_rdy, de, hs, vs, sof, uf;
    logic [7:0]  vdata;
    logic [15:0] ucnt;

    logic        srst2, en2, in_val2;
    logic [7:0]  in_data2;
    logic        in_rdy2, de2, hs2, vs2, sof2, uf2;
    logic [7:0]  vdata2;
    logic [15:0] ucnt2;

    int checks = 0;
    int fails  = 0;

    // Reference model: position in raster counted as enabled RUN cycles.
    bit         m_run = 0;
    int         m_tick = 0;
    bit         m_de = 0, m_hs = 0, m_vs = 0, m_sof = 0, m_uf = 0;
    logic [7:0] m_data = 8'h00;
    int         m_cnt = 0;
    logic [7:0] next_word = 8'd1;

    always #5 clk = ~clk;

    video_out_timing #(
        .WIDTH (8), .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1), .FILL (8'hEE)
    ) dut (
        .clk_i (clk), .srst_i (srst), .en_i (en), .in_val_i (in_val), .in_data_i (in_data),
        .in_rdy_o (in_rdy), .vid_de_o (de), .vid_hs_o (hs), .vid_vs_o (vs),
        .vid_data_o (vdata), .sof_o (sof), .underflow_o (uf), .underflow_cnt_o (ucnt)
    );

    // Nearly all-active raster so the 16-bit count saturates in a modest cycle budget.
    video_out_timing #(
        .WIDTH (8), .H_ACTIVE (1000), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (1000), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1), .FILL (8'hEE)
    ) dut_sat (
        .clk_i (clk), .srst_i (srst2), .en_i (en2), .in_val_i (in_val2), .in_data_i (in_data2),
        .in_rdy_o (in_rdy2), .vid_de_o (de2), .vid_hs_o (hs2), .vid_vs_o (vs2),
        .vid_data_o (vdata2), .sof_o (sof2), .underflow_o (uf2), .underflow_cnt_o (ucnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit e, input bit val, input bit rst);
        int h, v;
        bit a;
        srst    = rst;
        en      = e;
        in_val  = val;
        in_data = next_word;
        #1;
        h = m_tick % HT;
        v = (m_tick / HT) % VT;
        a = (h < 4) && (v < 3);
        chk("in_rdy", 32'(in_rdy), 32'(m_run && e && !rst && a));
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_tick = 0; m_de = 0; m_hs = 0; m_vs = 0; m_sof = 0;
            m_uf = 0; m_data = 8'h00; m_cnt = 0;
        end else if (e) begin
            if (!m_run) begin
                if (val) m_run = 1;
            end else begin
                m_de  = a;
                m_hs  = (h == 5) || (h == 6);
                m_vs  = (v == 4);
                m_sof = (m_tick % FT) == 0;
                if (!a) begin
                    m_data = 8'h00;
                end else if (val) begin
                    m_data = next_word;
                    next_word = next_word + 8'd1;
                end else begin
                    m_data = 8'hEE;
                    m_uf = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
                m_tick++;
            end
        end
        #1;
        chk("de", 32'(de), 32'(m_de));
        chk("hs", 32'(hs), 32'(m_hs));
        chk("vs", 32'(vs), 32'(m_vs));
        chk("data", 32'(vdata), 32'(m_data));
        chk("sof", 32'(sof), 32'(m_sof));
        chk("underflow", 32'(uf), 32'(m_uf));
        chk("underflow_cnt", 32'(ucnt), 32'(m_cnt));
    endtask

    initial begin
        int raw;
        int tick2;
        bit a2;
        srst2 = 1'b1; en2 = 1'b1; in_val2 = 1'b0; in_data2 = 8'h00;

        // Reset, then idle with no valid data.
        repeat (3) step(1, 0, 1);
        repeat (20) step(1, 0, 0);

        // Always-valid stream across more than two frames.
        repeat (110) step(1, 1, 0);

        // Underflow on the third active pixel of line 1.
        for (int i = 0; i < FT && (m_tick % FT) != 0; i++) step(1, 1, 0);
        for (int i = 0; i < FT; i++) step(1, (m_tick % FT) != 10, 0);

        // Enable toggling every cycle.
        for (int i = 0; i < 200; i++) step(i % 2 == 0, 1, 0);

        // Random enable and valid.
        for (int i = 0; i < 300; i++) step(($urandom % 4) != 0, ($urandom % 5) != 0, 0);

        // Reset in the middle of line 2, then restart.
        for (int i = 0; i < FT && (m_tick % FT) != 18; i++) step(1, 1, 0);
        step(1, 1, 1);
        repeat (3) step(1, 0, 0);
        repeat (60) step(1, 1, 0);

        // Saturation on the wide-raster instance.
        @(posedge clk); #1;
        srst2 = 1'b0; in_val2 = 1'b1;
        @(posedge clk); #1;
        in_val2 = 1'b0;
        raw = 0;
        tick2 = 0;
        for (int i = 0; i < 70000 && raw < 65540; i++) begin
            a2 = ((tick2 % 1003) < 1000) && (((tick2 / 1003) % 1003) < 1000);
            if (a2) raw++;
            @(posedge clk); #1;
            tick2++;
            if (a2 && raw == 65534) chk("cnt_pre_sat", 32'(ucnt2), 32'd65534);
        end
        chk("sat_reached", 32'(raw), 32'd65540);
        chk("cnt_saturated", 32'(ucnt2), 32'h0000FFFF);
        chk("underflow_sat", 32'(uf2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
